// File: rtl/crc_pkg.sv
// Shared types and standard generator polynomials for the PUSCH CRC attach chain.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        APPEND = 2'd2
    } state_e;

    localparam logic [23:0] CRC24A_POLY = 24'h864CFB;
    localparam logic [23:0] CRC24B_POLY = 24'h800063;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam logic [10:0] CRC11_POLY  = 11'h621;

endpackage

// File: rtl/crc_attach_lfsr.sv
// CRC_W-bit MSB-first CRC register with seed load, data step and zero-fill shift-out.
module crc_lfsr #(
    parameter int unsigned      CRC_W = 24,
    parameter logic [CRC_W-1:0] POLY  = '0,
    parameter logic [CRC_W-1:0] SEED  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_seed,
    input  logic             step,
    input  logic             din,
    input  logic             shift,
    output logic [CRC_W-1:0] lfsr,
    output logic [CRC_W-1:0] step_val
);

    logic [CRC_W-1:0] lfsr_q;

    assign lfsr = lfsr_q;

    // Value the register takes if the current din is absorbed; also used for CRC_OUT capture.
    always_comb begin
        step_val = {lfsr_q[CRC_W-2:0], 1'b0} ^ ((din ^ lfsr_q[CRC_W-1]) ? POLY : '0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lfsr_q <= SEED;
        end else if (load_seed) begin
            lfsr_q <= SEED;
        end else if (step) begin
            lfsr_q <= step_val;
        end else if (shift) begin
            lfsr_q <= {lfsr_q[CRC_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/crc_attach.sv
// Bit-serial CRC attacher: forwards data bits, then appends CRC_W parity bits MSB-first.
// Define CRC_CHECK_EN to add receive-check mode (CHECK_MODE input, CRC_OK output).
module crc_attach
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W = 24,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC24A_POLY),
    parameter logic [CRC_W-1:0] SEED  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic             IN_DATA,
    input  logic             IN_LAST,
    output logic             IN_READY,
    output logic             OUT_VALID,
    output logic             OUT_DATA,
    output logic             OUT_LAST,
    input  logic             OUT_READY,
    output logic [CRC_W-1:0] CRC_OUT,
    output logic             CRC_DONE,
    output logic             BUSY,
`ifdef CRC_CHECK_EN
    input  logic             CHECK_MODE,
    output logic             CRC_OK,
`endif
    output state_e           DBG_STATE
);

    localparam int unsigned      CNT_W    = $clog2(CRC_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CRC_W);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_data_q, out_last_q;
    logic [CRC_W-1:0] crc_q;
    logic             done_q;
    logic [CRC_W-1:0] lfsr_q, step_val;
    logic             load_seed, step, shift;
    logic             load_out, out_bit_d, out_last_d, frame_end;
    logic             can_load, in_xfer, out_xfer, check_eff;

    crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_lfsr (
        .CLK       (CLK),
        .RST       (RST),
        .load_seed (load_seed),
        .step      (step),
        .din       (IN_DATA),
        .shift     (shift),
        .lfsr      (lfsr_q),
        .step_val  (step_val)
    );

    // Handshake: a beat moves on a port when valid && ready in the same cycle. OUT_VALID is
    // only withdrawn by a transfer, and IN_READY follows output-stage space so a stalled
    // downstream stalls the upstream in the same cycle.
    assign can_load  = !out_valid_q || OUT_READY;
    assign IN_READY  = ((state_q == IDLE) || (state_q == DATA)) && can_load;
    assign in_xfer   = IN_VALID && IN_READY;
    assign out_xfer  = out_valid_q && OUT_READY;

    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_LAST  = out_last_q;
    assign CRC_OUT   = crc_q;
    assign CRC_DONE  = done_q;
    assign BUSY      = (state_q != IDLE);
    assign DBG_STATE = state_q;

`ifdef CRC_CHECK_EN
    logic check_q, ok_q;
    assign CRC_OK    = ok_q;
    // Mode is taken from the first bit of a frame and held for the rest of it.
    assign check_eff = (state_q == IDLE) ? CHECK_MODE : check_q;
`else
    assign check_eff = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_seed  = 1'b0;
        step       = 1'b0;
        shift      = 1'b0;
        load_out   = 1'b0;
        out_bit_d  = 1'b0;
        out_last_d = 1'b0;
        frame_end  = 1'b0;
        case (state_q)
            IDLE, DATA: begin
                if (in_xfer) begin
                    step       = 1'b1;
                    load_out   = 1'b1;
                    out_bit_d  = IN_DATA;
                    out_last_d = IN_LAST && check_eff;
                    if (IN_LAST) begin
                        frame_end = 1'b1;
                        cnt_d     = '0;
                        if (check_eff) begin
                            state_d   = IDLE;
                            load_seed = 1'b1;
                        end else begin
                            state_d = APPEND;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            APPEND: begin
                // cnt_q == CNT_END means every parity bit is loaded; wait for the last to drain.
                if (can_load && (cnt_q != CNT_END)) begin
                    shift      = 1'b1;
                    load_out   = 1'b1;
                    out_bit_d  = lfsr_q[CRC_W-1];
                    out_last_d = (cnt_q == CNT_LAST);
                    cnt_d      = cnt_q + 1'b1;
                end
                if (out_xfer && out_last_q) begin
                    state_d   = IDLE;
                    load_seed = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_last_q  <= 1'b0;
            crc_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_out) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_bit_d;
                out_last_q  <= out_last_d;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
            done_q <= frame_end;
            if (frame_end) begin
                crc_q <= step_val;
            end
        end
    end

`ifdef CRC_CHECK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            check_q <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            if (in_xfer && (state_q == IDLE)) begin
                check_q <= CHECK_MODE;
            end
            if (frame_end) begin
                ok_q <= (step_val == '0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_crc_attach.sv
// Self-checking bench for crc_attach (CRC16, poly 0x1021, seed 0); covers CRC_CHECK_EN when defined.
module tb_crc_attach;

    localparam int unsigned W = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID, IN_DATA, IN_LAST, IN_READY;
    logic          OUT_VALID, OUT_DATA, OUT_LAST, OUT_READY;
    logic [W-1:0]  CRC_OUT;
    logic          CRC_DONE, BUSY;
    crc_pkg::state_e dbg_state;
`ifdef CRC_CHECK_EN
    logic          CHECK_MODE, CRC_OK;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic          tx_bits[$];
    logic [0:0]    exp_q[$];

    typedef struct {
        string        name;
        int           nbits;
        logic [127:0] data;
        logic [W-1:0] exp_crc;
        bit           bp;
    } vec_t;

    vec_t vecs[$];

    crc_attach #(
        .CRC_W (W),
        .POLY  (16'h1021),
        .SEED  (16'h0000)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .IN_LAST   (IN_LAST),
        .IN_READY  (IN_READY),
        .OUT_VALID (OUT_VALID),
        .OUT_DATA  (OUT_DATA),
        .OUT_LAST  (OUT_LAST),
        .OUT_READY (OUT_READY),
        .CRC_OUT   (CRC_OUT),
        .CRC_DONE  (CRC_DONE),
        .BUSY      (BUSY),
`ifdef CRC_CHECK_EN
        .CHECK_MODE(CHECK_MODE),
        .CRC_OK    (CRC_OK),
`endif
        .DBG_STATE (dbg_state)
    );

    // Clock/reset block
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: remainder of M(x)*x^16 divided by G(x) = x^16+x^12+x^5+1, by long division.
    function automatic logic [W-1:0] ref_crc();
        logic         work[$];
        logic [W:0]   gen;
        logic [W-1:0] r;
        int           n;
        gen  = 17'h11021;
        work = tx_bits;
        n    = tx_bits.size();
        for (int i = 0; i < W; i++) work.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (work[i]) begin
                for (int j = 0; j <= W; j++) work[i+j] = work[i+j] ^ gen[W-j];
            end
        end
        for (int i = 0; i < W; i++) r[W-1-i] = work[n+i];
        return r;
    endfunction

    task automatic load_bits(input logic [127:0] data, input int nbits);
        tx_bits.delete();
        for (int i = 0; i < nbits; i++) tx_bits.push_back(data[nbits-1-i]);
    endtask

    task automatic add_vec(input string name, input int nbits, input logic [127:0] data,
                           input logic [W-1:0] exp_crc, input bit bp);
        vec_t v;
        v.name = name; v.nbits = nbits; v.data = data; v.exp_crc = exp_crc; v.bp = bp;
        vecs.push_back(v);
    endtask

    // Driver + scoreboard for one frame held in tx_bits. abort_beat > 0 pulses RST after
    // that many output beats have been taken.
    task automatic run_frame(input bit bp, input bit chk, input logic [W-1:0] exp_crc,
                             input int abort_beat);
        int   n, idx, beats, cyc, c0, last_cyc, done_cnt, rdy_viol;
        bit   done_due, finished, aborted, prev_stall;
        logic prev_d, prev_l;
        logic [0:0] e;
        n = tx_bits.size();
        idx = 0; beats = 0; cyc = 0; c0 = -1; last_cyc = -1; done_cnt = 0; rdy_viol = 0;
        done_due = 0; finished = 0; aborted = 0; prev_stall = 0; prev_d = 0; prev_l = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(tx_bits[i]);
        if (!chk) for (int b = W - 1; b >= 0; b--) exp_q.push_back(exp_crc[b]);

        while (!finished && !aborted && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (done_due) begin
                check("crc_done_pulse", CRC_DONE, 1'b1);
                check("crc_out", CRC_OUT, exp_crc);
`ifdef CRC_CHECK_EN
                check("crc_ok", CRC_OK, exp_crc == '0);
`endif
                done_due = 0;
            end
            if (CRC_DONE) done_cnt++;
            if (abort_beat > 0 && beats >= abort_beat) begin
                RST = 1'b0;
                #1;
                check("abort_out_valid", OUT_VALID, 1'b0);
                check("abort_out_data", OUT_DATA, 1'b0);
                check("abort_out_last", OUT_LAST, 1'b0);
                check("abort_crc_out", CRC_OUT, '0);
                check("abort_busy", BUSY, 1'b0);
                IN_VALID = 1'b0;
                IN_LAST  = 1'b0;
                @(negedge CLK);
                RST = 1'b1;
                aborted = 1;
            end else begin
                OUT_READY = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
`ifdef CRC_CHECK_EN
                CHECK_MODE = chk;
`endif
                if (idx < n) begin
                    IN_VALID = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                    IN_DATA  = tx_bits[idx];
                    IN_LAST  = (idx == n - 1);
                end else if (!chk) begin
                    IN_VALID = $urandom_range(0, 1);
                    IN_DATA  = $urandom_range(0, 1);
                    IN_LAST  = $urandom_range(0, 1);
                end else begin
                    IN_VALID = 1'b0;
                    IN_LAST  = 1'b0;
                end
                #1;
                if (prev_stall) begin
                    check("hold_valid", OUT_VALID, 1'b1);
                    check("hold_data", OUT_DATA, prev_d);
                    check("hold_last", OUT_LAST, prev_l);
                end
                prev_stall = OUT_VALID && !OUT_READY;
                prev_d = OUT_DATA;
                prev_l = OUT_LAST;
                if (prev_stall) check("stall_in_ready", IN_READY, 1'b0);
                if (idx == n && !chk && IN_READY) rdy_viol++;
                if (IN_VALID && IN_READY && idx < n) begin
                    if (c0 < 0) c0 = cyc;
                    if (IN_LAST) done_due = 1;
                    idx++;
                end
                if (OUT_VALID && OUT_READY) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", beats, n + (chk ? 0 : W));
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", OUT_DATA, e);
                        check("out_last", OUT_LAST, exp_q.size() == 0);
                    end
                    if (OUT_LAST) begin
                        finished = 1;
                        last_cyc = cyc;
                    end
                end
            end
        end
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
        if (!aborted) begin
            check("frame_timeout", finished, 1'b1);
            check("beat_count", beats, n + (chk ? 0 : W));
            check("done_count", done_cnt, 1);
            if (!chk) check("append_in_ready", rdy_viol, 0);
            if (!bp) check("latency", last_cyc - c0, n + (chk ? 0 : W));
            @(negedge CLK);
            OUT_READY = 1'b1;
            #1;
            check("idle_in_ready", IN_READY, 1'b1);
            check("idle_busy", BUSY, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] rc;
        int           nb;
        bit           bp;

        RST = 1'b0; IN_VALID = 1'b0; IN_DATA = 1'b0; IN_LAST = 1'b0; OUT_READY = 1'b0;
`ifdef CRC_CHECK_EN
        CHECK_MODE = 1'b0;
`endif
        add_vec("ascii_123456789", 72, 128'h313233343536373839, 16'h31C3, 1'b0);
        add_vec("single_one",       1, 128'h1,                  16'h1021, 1'b0);
        add_vec("zeros_40",        40, 128'h0,                  16'h0000, 1'b0);
        add_vec("ascii_backpress", 72, 128'h313233343536373839, 16'h31C3, 1'b1);

        repeat (3) @(negedge CLK);
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_out_data", OUT_DATA, 1'b0);
        check("rst_out_last", OUT_LAST, 1'b0);
        check("rst_crc_out", CRC_OUT, '0);
        check("rst_crc_done", CRC_DONE, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_state", dbg_state, crc_pkg::IDLE);
`ifdef CRC_CHECK_EN
        check("rst_crc_ok", CRC_OK, 1'b0);
`endif
        RST = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b1;
        #1;
        check("rst_in_ready", IN_READY, 1'b1);

        foreach (vecs[k]) begin
            load_bits(vecs[k].data, vecs[k].nbits);
            run_frame(vecs[k].bp, 1'b0, vecs[k].exp_crc, 0);
        end

        for (int r = 0; r < 6; r++) begin
            nb = $urandom_range(1, 60);
            bp = $urandom_range(0, 1);
            tx_bits.delete();
            for (int i = 0; i < nb; i++) tx_bits.push_back($urandom_range(0, 1));
            rc = ref_crc();
            run_frame(bp, 1'b0, rc, 0);
        end

        // Reset during the seventh parity bit, then a clean frame.
        load_bits(128'h313233343536373839, 72);
        run_frame(1'b0, 1'b0, 16'h31C3, 72 + 7);
        load_bits(128'h313233343536373839, 72);
        run_frame(1'b0, 1'b0, 16'h31C3, 0);

`ifdef CRC_CHECK_EN
        load_bits(128'h31323334353637383931C3, 88);
        run_frame(1'b0, 1'b1, ref_crc(), 0);
        load_bits(128'h31323334353637383931C3, 88);
        tx_bits[5] = ~tx_bits[5];
        run_frame(1'b0, 1'b1, ref_crc(), 0);
        load_bits(128'h31323334353637383931C3, 88);
        run_frame(1'b1, 1'b1, ref_crc(), 0);
        tx_bits.delete();
        tx_bits.push_back(1'b1);
        run_frame(1'b0, 1'b1, ref_crc(), 0);
        load_bits(128'h313233343536373839, 72);
        run_frame(1'b1, 1'b0, 16'h31C3, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/crc_attach.md
# crc_attach

Parametrised bit-serial CRC generator/attacher for the PUSCH transport-block and code-block chain. Covers CRC24A, CRC24B, CRC16 and CRC11 through parameters.

- Accepts a framed bit stream with valid/ready handshakes.
- Passes every data bit downstream and computes the CRC MSB-first.
- After the last data bit, appends the CRC_W parity bits MSB-first and flags the final bit.
- Optionally runs in receive-check mode instead of append mode.

## Interface
- CRC_W, 24, CRC length in bits (legal range 8..32).
- POLY, 24'h864CFB, generator polynomial without the implicit x^CRC_W term, CRC_W bits.
- SEED, 0, LFSR value loaded at each frame start, CRC_W bits.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  input bit valid.
- IN_DATA  in  1  input bit.
- IN_LAST  in  1  marks the last data bit of the frame.
- IN_READY  out  1  block accepts a bit this cycle.
- OUT_VALID  out  1  output bit valid.
- OUT_DATA  out  1  output bit (data bits, then parity bits).
- OUT_LAST  out  1  marks the last output bit of the frame.
- OUT_READY  in  1  downstream accepts a bit.
- CRC_OUT  out  CRC_W  final CRC of the last frame; held until the next frame completes.
- CRC_DONE  out  1  one-cycle pulse when CRC_OUT updates.
- BUSY  out  1  high in DATA and APPEND.

## Operation
- Transfers:
  - Input transfer: IN_VALID && IN_READY.
  - Output transfer: OUT_VALID && OUT_READY.
- LFSR update on each accepted data bit:
  - fb = IN_DATA ^ lfsr[CRC_W-1]
  - lfsr <= {lfsr[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
- The output stage is a single register (OUT_VALID/OUT_DATA/OUT_LAST).
  - It loads when empty or when it is emptied in the same cycle.
  - IN_READY = (state is IDLE or DATA) && (!OUT_VALID || OUT_READY). It is combinational from registers and OUT_READY.
- State machine:
  - IDLE: lfsr = SEED. First input transfer moves to DATA (or straight to APPEND if IN_LAST is set). That bit is processed normally.
  - DATA: each input transfer updates the LFSR and loads the bit into the output stage with OUT_LAST = 0. An input transfer with IN_LAST does the following:
    - latch the post-update LFSR into CRC_OUT;
    - pulse CRC_DONE the following cycle;
    - clear the parity counter;
    - move to APPEND.
  - APPEND: IN_READY = 0. Whenever the output stage can load, it loads lfsr[CRC_W-1], the LFSR shifts left by one (zero fill), and the counter increments. The bit loaded with counter == CRC_W-1 carries OUT_LAST = 1. Its output transfer returns the block to IDLE with lfsr = SEED.
- Single-bit frames (IN_LAST on the first bit) are legal and produce 1 + CRC_W output bits.
- OUT_VALID never drops while OUT_READY is low (no bubble withdrawal).
- IN_VALID or IN_LAST sampled without IN_READY are ignored.
- Asserting RST mid-frame aborts the frame. All state returns to reset values, and no partial parity is emitted.

## Timing
- Reset values:
  - OUT_VALID 0, OUT_DATA 0, OUT_LAST 0, CRC_OUT 0, CRC_DONE 0, BUSY 0, (CRC_OK 0).
  - State IDLE, lfsr = SEED.
  - IN_READY is 1 once RST is released.
- Latency is one cycle from input transfer to the same bit on OUT_DATA.
- Throughput is one bit per cycle. An N-bit frame with continuous IN_VALID and OUT_READY gives:
  - output beats at cycles 1..N+CRC_W after the first acceptance;
  - OUT_LAST at cycle N+CRC_W.
- CRC_DONE is asserted exactly one cycle after the IN_LAST transfer.
- With OUT_READY held low, the output stage holds its value and IN_READY = 0 until OUT_READY returns.
- A new frame's first bit can be accepted in the cycle after the OUT_LAST transfer.

## Configuration
- CRC_CHECK_EN defined:
  - Adds input CHECK_MODE (1 bit, sampled on the first bit of each frame) and output CRC_OK (1 bit, reset 0).
  - With CHECK_MODE = 1, APPEND is skipped and the IN_LAST bit is output with OUT_LAST = 1.
  - CRC_OK <= (post-update lfsr == 0) in the same cycle that CRC_DONE is asserted. It is held until the next CRC_DONE.
  - With CHECK_MODE = 0, behaviour is as without the macro.
- CRC_CHECK_EN undefined: no CHECK_MODE or CRC_OK ports, and the block always appends.

## Structure
- Package crc_pkg holds the following:
  - State enum {IDLE, DATA, APPEND}.
  - CRC24A_POLY = 24'h864CFB.
  - CRC24B_POLY = 24'h800063.
  - CRC16_POLY = 16'h1021.
  - CRC11_POLY = 11'h621.
- Sub-module crc_lfsr holds the CRC_W register. It has these controls:
  - seed load;
  - data-step with fb;
  - shift-out.
- crc_attach contains the FSM, parity counter ($clog2(CRC_W+1) bits), output stage and handshake logic.

## Test plan
- CRC_W=16, POLY=16'h1021, SEED=0, ASCII "123456789" (72 bits, MSB-first, continuous) -> CRC_OUT = 16'h31C3, CRC_DONE one pulse, 88 output beats, last 16 bits = 0x31C3, OUT_LAST on beat 88.
- Same config, single bit 1 with IN_LAST -> CRC_OUT = 16'h1021, output = 1 followed by 0001_0000_0010_0001, 17 beats.
- Same config, 40 zero bits -> CRC_OUT = 0, 16 zero parity bits appended.
- Backpressure: "123456789" with OUT_READY toggling pseudo-randomly and IN_VALID gapped -> identical output bit sequence, no lost or duplicated bits, IN_READY = 0 throughout APPEND.
- CRC_CHECK_EN, CHECK_MODE=1, "123456789" followed by 16'h31C3 (88 bits) -> CRC_OK = 1, 88 output beats, no append. Flip bit 5 -> CRC_OK = 0.
- RST pulsed low during APPEND (parity bit 7) -> all outputs 0 immediately. Next frame "123456789" -> CRC_OUT = 16'h31C3.
